// File: rtl/seg_chase_multi.sv
// Seven-segment "chase" animation across NUM_DIGITS digits.
// Mode 0 spins one lit segment (a..f) identically on every digit.
// Mode 1 runs a single lit segment around the outer perimeter of the display.
module seg_chase_multi #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    mode,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    step,
  output logic                    wrap
);

  localparam int         CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [4:0] LAST_M0  = 5'd5;
  localparam logic [4:0] LAST_M1  = 5'(2 * NUM_DIGITS + 3);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4:0]              pos_q, pos_d;
  logic                    mode_q, mode_d;
  logic                    step_q, step_d;
  logic                    wrap_q, wrap_d;
  logic                    tick;
  logic [4:0]              last_pos;
  logic [7*NUM_DIGITS-1:0] lit;

  assign tick     = en && (cnt_q == CNT_MAX);
  assign last_pos = mode_q ? LAST_M1 : LAST_M0;

  // Next-state: a mode change restarts the sequence and beats any tick; otherwise advance on tick.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    mode_d = mode;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (mode != mode_q) begin
      cnt_d = '0;
      pos_d = '0;
    end else if (en) begin
      if (tick) begin
        cnt_d  = '0;
        step_d = 1'b1;
        if (!dir) begin
          if (pos_q == last_pos) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q + 5'd1;
          end
        end else begin
          if (pos_q == 5'd0) begin
            pos_d  = last_pos;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q - 5'd1;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset re-captures the mode input so no spurious restart follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      mode_q <= mode;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      mode_q <= mode_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  // Decode the registered position into lit segments (1 = lit, before polarity).
  always_comb begin
    lit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!mode_q) begin
        for (int s = 0; s < 6; s++) begin
          if (int'(pos_q) == s) lit[7*k+s] = 1'b1;
        end
      end else begin
        if (int'(pos_q) == NUM_DIGITS - 1 - k) lit[7*k]   = 1'b1;
        if (int'(pos_q) == NUM_DIGITS + 2 + k) lit[7*k+3] = 1'b1;
        if (k == 0) begin
          if (int'(pos_q) == NUM_DIGITS)     lit[1] = 1'b1;
          if (int'(pos_q) == NUM_DIGITS + 1) lit[2] = 1'b1;
        end
        if (k == NUM_DIGITS - 1) begin
          if (int'(pos_q) == 2 * NUM_DIGITS + 2) lit[7*k+4] = 1'b1;
          if (int'(pos_q) == 2 * NUM_DIGITS + 3) lit[7*k+5] = 1'b1;
        end
      end
    end
  end

  assign seg  = (ACTIVE_LOW != 0) ? ~lit : lit;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule
